pll_lock_supervisor: RTL and testbench

- Consumes the lock indication of the system PLL and produces a clean, debounced core reset.
- Generates phase-aligned clock enables (÷2, ÷4, ÷8, ÷16) from the 48.387096 MHz master clock, replacing the separate 24/12/6/3 MHz PLL outputs.
- Sits between the PLL wrapper and the game core; counts PLL lock losses for the OSD/debug status.

---
 rtl/pll_sup_pkg.sv | 20 ++
 rtl/sync_ff2.sv | 25 ++
 rtl/pll_lock_supervisor.sv | 168 ++++++++++++++++
 tb/tb_pll_lock_supervisor.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pll_sup_pkg.sv
// Shared types and constants for the PLL lock supervisor: FSM states,
// divider width and the clock-enable decode masks.
package pll_sup_pkg;

  typedef enum logic [2:0] {
    WAIT_LOCK = 3'd0,
    HOLD      = 3'd1,
    RUN       = 3'd2,
    LOST      = 3'd3,
    PLL_RST   = 3'd4
  } state_e;

  localparam int DIV_W = 4;

  localparam logic [DIV_W-1:0] CE24_MASK = 4'd1;
  localparam logic [DIV_W-1:0] CE12_MASK = 4'd3;
  localparam logic [DIV_W-1:0] CE6_MASK  = 4'd7;
  localparam logic [DIV_W-1:0] CE3_MASK  = 4'd15;

endpackage

// File: rtl/sync_ff2.sv
// Two-flop synchronizer with synchronous active-high reset; both stages
// clear to 0. Reusable for any single-bit asynchronous input.
module sync_ff2 (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/pll_lock_supervisor.sv
// Debounces PLL lock into a clean core reset, derives /2../16 clock enables
// in RUN and counts lock losses. Define PLL_SUPERVISOR_RELOCK_EN for PLL_RST.
module pll_lock_supervisor
  import pll_sup_pkg::*;
#(
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int RESET_HOLD_CYCLES  = 256,
  parameter int PLL_RST_CYCLES     = 16,
  parameter int LOSS_CNT_W         = 8
) (
  input  logic                  clk_sys,
  input  logic                  reset,
  input  logic                  pll_locked,
  output logic                  core_reset,
  output logic                  ready,
  output logic                  ce_24,
  output logic                  ce_12,
  output logic                  ce_6,
  output logic                  ce_3,
  output logic [LOSS_CNT_W-1:0] loss_cnt,
  output logic                  pll_rst
);

  localparam int SW = $clog2(LOCK_STABLE_CYCLES + 1);
  localparam int HW = $clog2(RESET_HOLD_CYCLES + 1);

  logic lk_s;

  sync_ff2 u_lock_sync (
    .clk_i (clk_sys),
    .rst_i (reset),
    .d_i   (pll_locked),
    .q_o   (lk_s)
  );

  state_e                  state_q, state_d;
  logic [SW-1:0]           stab_q, stab_d;
  logic [HW-1:0]           hold_q, hold_d;
  logic [DIV_W-1:0]        div_q, div_d;
  logic [LOSS_CNT_W-1:0]   loss_q, loss_d;
  logic                    core_reset_q, ready_q, pll_rst_q;
  logic                    ce_24_q, ce_12_q, ce_6_q, ce_3_q;
  logic                    run_d;

`ifdef PLL_SUPERVISOR_RELOCK_EN
  localparam int RW = $clog2(PLL_RST_CYCLES + 1);
  logic [RW-1:0] rst_q, rst_d;
`else
  logic unused_pll_rst_cycles;
  assign unused_pll_rst_cycles = (PLL_RST_CYCLES == 0);
`endif

  always_comb begin
    state_d = state_q;
    stab_d  = stab_q;
    hold_d  = hold_q;
    div_d   = '0;
    loss_d  = loss_q;
`ifdef PLL_SUPERVISOR_RELOCK_EN
    rst_d   = rst_q;
`endif
    case (state_q)
      WAIT_LOCK: begin
        if (!lk_s) begin
          stab_d = '0;
        end else if (stab_q == SW'(LOCK_STABLE_CYCLES - 1)) begin
          state_d = HOLD;
          stab_d  = '0;
          hold_d  = '0;
        end else begin
          stab_d = stab_q + SW'(1);
        end
      end
      HOLD: begin
        hold_d = hold_q + HW'(1);
        // Losing lock outranks reaching the terminal count.
        if (!lk_s) begin
          state_d = LOST;
        end else if (hold_q == HW'(RESET_HOLD_CYCLES - 1)) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (!lk_s) begin
          state_d = LOST;
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      LOST: begin
        stab_d = '0;
`ifdef PLL_SUPERVISOR_RELOCK_EN
        state_d = PLL_RST;
        rst_d   = '0;
`else
        state_d = WAIT_LOCK;
`endif
      end
`ifdef PLL_SUPERVISOR_RELOCK_EN
      PLL_RST: begin
        rst_d = rst_q + RW'(1);
        if (rst_q == RW'(PLL_RST_CYCLES - 1)) begin
          state_d = WAIT_LOCK;
        end
      end
`endif
      default: begin
        state_d = WAIT_LOCK;
      end
    endcase
    // Count on entry so loss_cnt already reflects the loss during LOST.
    if (state_d == LOST && state_q != LOST && loss_q != '1) begin
      loss_d = loss_q + LOSS_CNT_W'(1);
    end
  end

  assign run_d = (state_d == RUN);

  // Outputs are registered from next-state values, so they equal a decode
  // of the registered state without any path from pll_locked.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q      <= WAIT_LOCK;
      stab_q       <= '0;
      hold_q       <= '0;
      div_q        <= '0;
      loss_q       <= '0;
      core_reset_q <= 1'b1;
      ready_q      <= 1'b0;
      ce_24_q      <= 1'b0;
      ce_12_q      <= 1'b0;
      ce_6_q       <= 1'b0;
      ce_3_q       <= 1'b0;
      pll_rst_q    <= 1'b0;
`ifdef PLL_SUPERVISOR_RELOCK_EN
      rst_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      stab_q       <= stab_d;
      hold_q       <= hold_d;
      div_q        <= div_d;
      loss_q       <= loss_d;
      core_reset_q <= !run_d;
      ready_q      <= run_d;
      ce_24_q      <= run_d && ((div_d & CE24_MASK) == CE24_MASK);
      ce_12_q      <= run_d && ((div_d & CE12_MASK) == CE12_MASK);
      ce_6_q       <= run_d && ((div_d & CE6_MASK) == CE6_MASK);
      ce_3_q       <= run_d && ((div_d & CE3_MASK) == CE3_MASK);
`ifdef PLL_SUPERVISOR_RELOCK_EN
      rst_q        <= rst_d;
      pll_rst_q    <= (state_d == PLL_RST);
`else
      pll_rst_q    <= 1'b0;
`endif
    end
  end

  assign core_reset = core_reset_q;
  assign ready      = ready_q;
  assign ce_24      = ce_24_q;
  assign ce_12      = ce_12_q;
  assign ce_6       = ce_6_q;
  assign ce_3       = ce_3_q;
  assign loss_cnt   = loss_q;
  assign pll_rst    = pll_rst_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed bench for pll_lock_supervisor with LOCK_STABLE=8, HOLD=4, PLL_RST=3.
// Edge 0 is the edge after which pll_locked is changed; samples are #1 after edges.
module tb_pll_lock_supervisor;

  localparam int LSC = 8;
  localparam int RHC = 4;
  localparam int PRC = 3;
  localparam int LW  = 8;

  logic          clk_sys = 1'b0;
  logic          reset = 1'b1;
  logic          pll_locked = 1'b0;
  logic          core_reset, ready, ce_24, ce_12, ce_6, ce_3, pll_rst;
  logic [LW-1:0] loss_cnt;
  logic [5:0]    outs;

  int vectors = 0;
  int miscompares = 0;

  pll_lock_supervisor #(
    .LOCK_STABLE_CYCLES (LSC),
    .RESET_HOLD_CYCLES  (RHC),
    .PLL_RST_CYCLES     (PRC),
    .LOSS_CNT_W         (LW)
  ) dut (
    .clk_sys    (clk_sys),
    .reset      (reset),
    .pll_locked (pll_locked),
    .core_reset (core_reset),
    .ready      (ready),
    .ce_24      (ce_24),
    .ce_12      (ce_12),
    .ce_6       (ce_6),
    .ce_3       (ce_3),
    .loss_cnt   (loss_cnt),
    .pll_rst    (pll_rst)
  );

  assign outs = {core_reset, ready, ce_24, ce_12, ce_6, ce_3};

  always #5 clk_sys = ~clk_sys;

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    pll_locked = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    pll_locked = 1'b1;
    tick();
    tick();
    vectors++;
    if (outs !== 6'b100000) begin
      miscompares++;
      $display("FAIL reset_outs got=%b want=%b", outs, 6'b100000);
    end
    vectors++;
    if (loss_cnt !== 8'd0) begin
      miscompares++;
      $display("FAIL reset_loss got=%0d want=0", loss_cnt);
    end
    vectors++;
    if (pll_rst !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_pll_rst got=%b want=0", pll_rst);
    end
    pll_locked = 1'b0;
    reset = 1'b0;
    $display("test_reset done");
  endtask

  task automatic test_clean_lock();
    logic [5:0] exp;
    int d;
    do_reset();
    tick();
    pll_locked = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      tick();
      d = k - 14;
      if (k < 14) exp = 6'b100000;
      else exp = {1'b0, 1'b1, (d % 2) == 1, (d % 4) == 3, (d % 8) == 7, (d % 16) == 15};
      vectors++;
      if (outs !== exp) begin
        miscompares++;
        $display("FAIL clean_lock_edge%0d got=%b want=%b", k, outs, exp);
      end
      vectors++;
      if (pll_rst !== 1'b0) begin
        miscompares++;
        $display("FAIL clean_lock_pll_rst_edge%0d got=%b want=0", k, pll_rst);
      end
    end
    $display("test_clean_lock done");
  endtask

  task automatic test_glitchy_lock();
    do_reset();
    tick();
    pll_locked = 1'b1;
    repeat (5) tick();
    pll_locked = 1'b0;
    tick();
    pll_locked = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      tick();
      vectors++;
      if (ready !== (k == 14)) begin
        miscompares++;
        $display("FAIL glitch_ready_edge%0d got=%b want=%b", k, ready, (k == 14));
      end
    end
    vectors++;
    if (loss_cnt !== 8'd0) begin
      miscompares++;
      $display("FAIL glitch_loss got=%0d want=0", loss_cnt);
    end
    $display("test_glitchy_lock done");
  endtask

  task automatic test_loss_in_run();
    logic exp_rst;
    do_reset();
    tick();
    pll_locked = 1'b1;
    repeat (17) tick();
    vectors++;
    if (ready !== 1'b1) begin
      miscompares++;
      $display("FAIL run_pre_ready got=%b want=1", ready);
    end
    pll_locked = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (k <= 2) begin
        vectors++;
        if (ready !== 1'b1) begin
          miscompares++;
          $display("FAIL run_drop_ready_edge%0d got=%b want=1", k, ready);
        end
      end else begin
        vectors++;
        if (outs !== 6'b100000) begin
          miscompares++;
          $display("FAIL run_drop_outs_edge%0d got=%b want=%b", k, outs, 6'b100000);
        end
      end
`ifdef PLL_SUPERVISOR_RELOCK_EN
      exp_rst = (k >= 4) && (k <= 6);
`else
      exp_rst = 1'b0;
`endif
      vectors++;
      if (pll_rst !== exp_rst) begin
        miscompares++;
        $display("FAIL run_drop_pll_rst_edge%0d got=%b want=%b", k, pll_rst, exp_rst);
      end
    end
    vectors++;
    if (loss_cnt !== 8'd1) begin
      miscompares++;
      $display("FAIL run_drop_loss got=%0d want=1", loss_cnt);
    end
    pll_locked = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      tick();
      vectors++;
      if (ready !== (k == 14)) begin
        miscompares++;
        $display("FAIL relock_ready_edge%0d got=%b want=%b", k, ready, (k == 14));
      end
    end
    vectors++;
    if (loss_cnt !== 8'd1) begin
      miscompares++;
      $display("FAIL relock_loss got=%0d want=1", loss_cnt);
    end
    $display("test_loss_in_run done");
  endtask

  // Drop lands so lk_s falls exactly when hold_cnt hits terminal count.
  task automatic test_loss_in_hold();
    do_reset();
    tick();
    pll_locked = 1'b1;
    repeat (11) tick();
    pll_locked = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      vectors++;
      if (ready !== 1'b0 || core_reset !== 1'b1) begin
        miscompares++;
        $display("FAIL hold_drop_edge%0d got ready=%b core_reset=%b want ready=0 core_reset=1",
                 k, ready, core_reset);
      end
    end
    vectors++;
    if (loss_cnt !== 8'd1) begin
      miscompares++;
      $display("FAIL hold_drop_loss got=%0d want=1", loss_cnt);
    end
    $display("test_loss_in_hold done");
  endtask

  task automatic test_saturation_and_reset();
    do_reset();
    for (int i = 0; i < 260; i++) begin
      tick();
      pll_locked = 1'b1;
      repeat (11) tick();
      pll_locked = 1'b0;
      repeat (8) tick();
      if (i == 0 || i == 253 || i == 254 || i == 259) begin
        vectors++;
        if (loss_cnt !== ((i >= 254) ? 8'd255 : 8'(i + 1))) begin
          miscompares++;
          $display("FAIL sat_loss_after%0d got=%0d want=%0d", i + 1, loss_cnt,
                   (i >= 254) ? 255 : i + 1);
        end
      end
    end
    tick();
    pll_locked = 1'b1;
    repeat (14) tick();
    vectors++;
    if (ready !== 1'b1 || loss_cnt !== 8'd255) begin
      miscompares++;
      $display("FAIL sat_run got ready=%b loss=%0d want ready=1 loss=255", ready, loss_cnt);
    end
    repeat (3) tick();
    reset = 1'b1;
    tick();
    vectors++;
    if (outs !== 6'b100000) begin
      miscompares++;
      $display("FAIL midrun_reset_outs got=%b want=%b", outs, 6'b100000);
    end
    vectors++;
    if (loss_cnt !== 8'd0) begin
      miscompares++;
      $display("FAIL midrun_reset_loss got=%0d want=0", loss_cnt);
    end
    reset = 1'b0;
    pll_locked = 1'b0;
    $display("test_saturation_and_reset done");
  endtask

  initial begin
    test_reset();
    test_clean_lock();
    test_glitchy_lock();
    test_loss_in_run();
    test_loss_in_hold();
    test_saturation_and_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout want=completion");
    $fatal(1, "watchdog expired");
  end

endmodule
